// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I core (OP, OP-IMM, LUI) with a req/ack fetch port and FETCH/DECODE/EXECUTE/WRITEBACK/HALT FSM.
// Optional MULTICYCLE_CPU_REG_DEBUG_INIT_EN: registers reset to i+3000 instead of 0.
module multicycle_cpu #(
  parameter int          XLEN     = 32,
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [31:0]     pc,
  output logic            halted,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  input  logic [4:0]      dbg_reg_addr,
  output logic [XLEN-1:0] dbg_reg_data
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("multicycle_cpu: XLEN must be 32 for RV32I");
    end
    if (NUM_REGS < 2 || NUM_REGS > 32 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
      $error("multicycle_cpu: NUM_REGS must be a power of two between 2 and 32");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  state_t          state_reg;
  logic [31:0]     pc_reg;
  logic [31:0]     ir_reg;
  logic            halted_reg;
  logic            retire_valid_reg;
  logic [4:0]      retire_rd_reg;
  logic [XLEN-1:0] retire_data_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [2:0]      f3_reg;
  logic            alt_reg;
  logic [XLEN-1:0] regs [NUM_REGS];

  // Out-of-range indices (NUM_REGS < 32) behave like x0.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NUM_REGS) return '0;
    return regs[idx[RW-1:0]];
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_field;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;

  assign opcode   = ir_reg[6:0];
  assign funct3   = ir_reg[14:12];
  assign funct7   = ir_reg[31:25];
  assign rd_field = ir_reg[11:7];
  assign i_imm    = {{20{ir_reg[31]}}, ir_reg[31:20]};
  assign u_imm    = {ir_reg[31:12], 12'b0};

  logic            dec_legal;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [2:0]      dec_f3;
  logic            dec_alt;

  always_comb begin
    dec_legal = 1'b0;
    dec_a     = rf_read(ir_reg[19:15]);
    dec_b     = rf_read(ir_reg[24:20]);
    dec_f3    = funct3;
    dec_alt   = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_alt   = funct7[5];
        dec_legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      7'b0010011: begin
        dec_b = i_imm;
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'b0000000);
          3'b101: begin
            // imm[10] selects SRAI; every other imm[11:5] pattern is reserved
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_alt   = funct7[5];
          end
          default: dec_legal = 1'b1;
        endcase
      end
      7'b0110111: begin
        dec_legal = 1'b1;
        dec_a     = '0;
        dec_b     = u_imm;
        dec_f3    = 3'b000;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;

  assign shamt = b_reg[4:0];

  always_comb begin
    alu_result = '0;
    case (f3_reg)
      3'b000:  alu_result = alt_reg ? (a_reg - b_reg) : (a_reg + b_reg);
      3'b001:  alu_result = a_reg << shamt;
      3'b010:  alu_result = {{(XLEN-1){1'b0}}, $signed(a_reg) < $signed(b_reg)};
      3'b011:  alu_result = {{(XLEN-1){1'b0}}, a_reg < b_reg};
      3'b100:  alu_result = a_reg ^ b_reg;
      3'b101:  alu_result = alt_reg ? XLEN'($signed(a_reg) >>> shamt) : (a_reg >> shamt);
      3'b110:  alu_result = a_reg | b_reg;
      default: alu_result = a_reg & b_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_FETCH;
      pc_reg           <= RESET_PC;
      ir_reg           <= '0;
      halted_reg       <= 1'b0;
      retire_valid_reg <= 1'b0;
      retire_rd_reg    <= '0;
      retire_data_reg  <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      f3_reg           <= '0;
      alt_reg          <= 1'b0;
    end else begin
      retire_valid_reg <= 1'b0;
      case (state_reg)
        ST_FETCH: begin
          if (imem_ack) begin
            ir_reg    <= imem_rdata;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_legal) begin
            a_reg     <= dec_a;
            b_reg     <= dec_b;
            f3_reg    <= dec_f3;
            alt_reg   <= dec_alt;
            state_reg <= ST_EXECUTE;
          end else begin
            halted_reg <= 1'b1;
            state_reg  <= ST_HALT;
          end
        end
        ST_EXECUTE: begin
          // Retire outputs are registered here so they are valid throughout WRITEBACK.
          retire_valid_reg <= 1'b1;
          retire_rd_reg    <= rd_field;
          retire_data_reg  <= alu_result;
          state_reg        <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          pc_reg    <= pc_reg + 32'd4;
          state_reg <= ST_FETCH;
        end
        default: state_reg <= ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
`ifdef MULTICYCLE_CPU_REG_DEBUG_INIT_EN
        regs[i] <= (i == 0) ? '0 : XLEN'(i + 3000);
`else
        regs[i] <= '0;
`endif
      end
    end else if (state_reg == ST_WRITEBACK && rd_field != 5'd0 && int'(rd_field) < NUM_REGS) begin
      regs[rd_field[RW-1:0]] <= retire_data_reg;
    end
  end

  // Gating with reset_n makes the request drop the instant reset asserts.
  assign imem_req     = reset_n && (state_reg == ST_FETCH);
  assign imem_addr    = pc_reg;
  assign pc           = pc_reg;
  assign halted       = halted_reg;
  assign retire_valid = retire_valid_reg;
  assign retire_rd    = retire_rd_reg;
  assign retire_data  = retire_data_reg;
  assign dbg_reg_data = rf_read(dbg_reg_addr);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed self-checking bench for multicycle_cpu: wait-stated instruction memory model plus retire monitor.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc;
  logic        halted;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic [4:0]  dbg_reg_addr = 5'd0;
  logic [31:0] dbg_reg_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_wait = 0;
  int wait_cnt = 0;
  int addr_err = 0;
  bit stray_en = 1'b0;
  bit in_fetch = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic [31:0] mem [64];

  int          ret_cyc[$];
  logic [4:0]  ret_rd[$];
  logic [31:0] ret_data[$];

`ifdef MULTICYCLE_CPU_REG_DEBUG_INIT_EN
  localparam logic [31:0] X5_RESET = 32'd3005;
`else
  localparam logic [31:0] X5_RESET = 32'd0;
`endif

  always #5 clk = ~clk;

  multicycle_cpu dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .pc           (pc),
    .halted       (halted),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data)
  );

  // Instruction memory: acks after ack_wait wait cycles; optional stray acks while idle.
  initial begin : responder
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && imem_req) begin
        if (wait_cnt >= ack_wait) begin
          imem_ack = 1'b1;
          imem_rdata = mem[imem_addr[7:2]];
          wait_cnt = 0;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = 32'hDEADBEEF;
          wait_cnt++;
        end
      end else begin
        imem_ack = stray_en && reset_n;
        imem_rdata = 32'h0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc = reset_n ? cyc + 1 : 0;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (retire_valid === 1'b1) begin
        ret_cyc.push_back(cyc + 1);
        ret_rd.push_back(retire_rd);
        ret_data.push_back(retire_data);
        $display("retire cycle=%0d rd=x%0d data=0x%08h pc=0x%08h", cyc + 1, retire_rd, retire_data, pc);
      end
      if (!reset_n || imem_req !== 1'b1) begin
        in_fetch = 1'b0;
      end else begin
        if (in_fetch && imem_addr !== fetch_addr) addr_err++;
        if (imem_addr !== pc) addr_err++;
        in_fetch = 1'b1;
        fetch_addr = imem_addr;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic start(input int waits);
    reset_n = 1'b0;
    ack_wait = waits;
    stray_en = 1'b0;
    repeat (2) @(negedge clk);
    ret_cyc.delete();
    ret_rd.delete();
    ret_data.delete();
    addr_err = 0;
    reset_n = 1'b1;
  endtask

  task automatic run_to_halt(input int max_cyc);
    int n = 0;
    while (halted !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_timeout: halted=%b required 1 after %0d cycles", halted, max_cyc);
    end
  endtask

  task automatic test_reset();
    clear_mem();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", pc); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
    vectors++; if (retire_valid !== 1'b0) begin miscompares++; $display("FAIL reset_retire_valid: got %b want 0", retire_valid); end
    vectors++; if (retire_rd !== 5'd0 || retire_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_retire_fields: got rd=%0d data=%h want 0/0", retire_rd, retire_data);
    end
    dbg_reg_addr = 5'd5; #1;
    vectors++; if (dbg_reg_data !== X5_RESET) begin miscompares++; $display("FAIL reset_x5: got %h want %h", dbg_reg_data, X5_RESET); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL first_fetch: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic check_basic_retires(input string tag, input int period);
    vectors++;
    if (ret_rd.size() !== 3) begin
      miscompares++; $display("FAIL %s_count: got %0d retires want 3", tag, ret_rd.size());
    end else begin
      logic [4:0]  exp_rd [3] = '{5'd5, 5'd6, 5'd7};
      logic [31:0] exp_d  [3] = '{32'd5, 32'd7, 32'd12};
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (ret_cyc[i] !== period * (i + 1) || ret_rd[i] !== exp_rd[i] || ret_data[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL %s_retire%0d: got cyc=%0d rd=%0d data=%h want cyc=%0d rd=%0d data=%h",
                   tag, i, ret_cyc[i], ret_rd[i], ret_data[i], period * (i + 1), exp_rd[i], exp_d[i]);
        end
      end
    end
    vectors++; if (pc !== 32'd12) begin miscompares++; $display("FAIL %s_pc: got %h want 0000000c", tag, pc); end
    dbg_reg_addr = 5'd7; #1;
    vectors++; if (dbg_reg_data !== 32'd12) begin miscompares++; $display("FAIL %s_x7: got %h want 0000000c", tag, dbg_reg_data); end
    vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL %s_addr_stable: got %0d violations want 0", tag, addr_err); end
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = 32'h00500293;
    mem[1] = 32'h00700313;
    mem[2] = 32'h005303b3;
  endtask

  task automatic test_basic_program();
    load_basic();
    start(0);
    run_to_halt(60);
    check_basic_retires("basic", 4);
  endtask

  task automatic test_shift_slt();
    logic [4:0]  exp_rd [5] = '{5'd5, 5'd10, 5'd11, 5'd12, 5'd13};
    logic [31:0] exp_d  [5] = '{32'd5, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'd1, 32'd0};
    clear_mem();
    mem[0] = 32'h00500293;
    mem[1] = 32'hff000513;
    mem[2] = 32'h40255593;
    mem[3] = 32'h00552633;
    mem[4] = 32'h005536b3;
    start(0);
    run_to_halt(80);
    vectors++;
    if (ret_rd.size() !== 5) begin
      miscompares++; $display("FAIL slt_count: got %0d retires want 5", ret_rd.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (ret_rd[i] !== exp_rd[i] || ret_data[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL slt_retire%0d: got rd=%0d data=%h want rd=%0d data=%h", i, ret_rd[i], ret_data[i], exp_rd[i], exp_d[i]);
        end
      end
    end
    dbg_reg_addr = 5'd11; #1;
    vectors++; if (dbg_reg_data !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL srai_x11: got %h want fffffffc", dbg_reg_data); end
    dbg_reg_addr = 5'd12; #1;
    vectors++; if (dbg_reg_data !== 32'd1) begin miscompares++; $display("FAIL slt_x12: got %h want 1", dbg_reg_data); end
    dbg_reg_addr = 5'd13; #1;
    vectors++; if (dbg_reg_data !== 32'd0) begin miscompares++; $display("FAIL sltu_x13: got %h want 0", dbg_reg_data); end
  endtask

  task automatic test_alu_mix();
    logic [31:0] prog [19] = '{
      32'h123450B7, 32'h0F000113, 32'h0FF00193, 32'h00314233, 32'h0030E2B3,
      32'h0022F333, 32'h403103B3, 32'h00419433, 32'h0043D4B3, 32'h4043D733,
      32'hFFF1C793, 32'hFFF1B813, 32'h00419893, 32'h7F02F913, 32'h00F16993,
      32'h0003AA13, 32'h01C3DA93, 32'h00000000, 32'h00000000};
    logic [4:0] exp_rd [17] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};
    logic [31:0] exp_d [17] = '{
      32'h12345000, 32'h000000F0, 32'h000000FF, 32'h0000000F, 32'h123450FF,
      32'h000000F0, 32'hFFFFFFF1, 32'h007F8000, 32'h0001FFFF, 32'hFFFFFFFF,
      32'hFFFFFF00, 32'h00000001, 32'h00000FF0, 32'h000000F0, 32'h000000FF,
      32'h00000001, 32'h0000000F};
    clear_mem();
    for (int i = 0; i < 19; i++) mem[i] = prog[i];
    start(0);
    run_to_halt(200);
    vectors++;
    if (ret_rd.size() !== 17) begin
      miscompares++; $display("FAIL mix_count: got %0d retires want 17", ret_rd.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        vectors++;
        if (ret_rd[i] !== exp_rd[i] || ret_data[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL mix_retire%0d: got rd=%0d data=%h want rd=%0d data=%h", i, ret_rd[i], ret_data[i], exp_rd[i], exp_d[i]);
        end
      end
    end
    vectors++; if (pc !== 32'd68) begin miscompares++; $display("FAIL mix_halt_pc: got %h want 00000044", pc); end
  endtask

  task automatic test_wait_states();
    load_basic();
    start(3);
    stray_en = 1'b1;
    run_to_halt(120);
    check_basic_retires("wait", 7);
    stray_en = 1'b0;
  endtask

  task automatic test_illegal();
    int bad = 0;
    load_basic();
    mem[2] = 32'h00000000;
    start(0);
    while (cyc < 9) @(negedge clk);
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early: got %b want 0 in DECODE", halted); end
    while (cyc < 10) @(negedge clk);
    vectors++; if (halted !== 1'b1 || pc !== 32'd8) begin
      miscompares++; $display("FAIL halt_rise: got halted=%b pc=%h want 1/00000008", halted, pc);
    end
    stray_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || pc !== 32'd8 || retire_valid !== 1'b0 || halted !== 1'b1) bad++;
    end
    stray_en = 1'b0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL halt_frozen: got %0d bad cycles want 0", bad); end
    vectors++; if (ret_rd.size() !== 2) begin miscompares++; $display("FAIL halt_retires: got %0d want 2", ret_rd.size()); end
    // Reserved shift-immediate encoding (SLLI with imm[11:5]=0100000).
    clear_mem();
    mem[0] = 32'h40419893;
    start(0);
    run_to_halt(20);
    vectors++; if (pc !== 32'd0 || ret_rd.size() !== 0) begin
      miscompares++; $display("FAIL bad_slli: got pc=%h retires=%0d want 0/0", pc, ret_rd.size());
    end
  endtask

  task automatic test_x0_write();
    clear_mem();
    mem[0] = 32'h00900013;
    start(0);
    run_to_halt(40);
    vectors++;
    if (ret_rd.size() !== 1 || ret_cyc[0] !== 4 || ret_rd[0] !== 5'd0 || ret_data[0] !== 32'd9) begin
      miscompares++;
      $display("FAIL x0_retire: got n=%0d cyc=%0d rd=%0d data=%h want 1/4/0/00000009", ret_rd.size(), ret_cyc[0], ret_rd[0], ret_data[0]);
    end
    dbg_reg_addr = 5'd0; #1;
    vectors++; if (dbg_reg_data !== 32'd0) begin miscompares++; $display("FAIL x0_read: got %h want 0", dbg_reg_data); end
  endtask

  task automatic test_reset_midfetch();
    load_basic();
    start(3);
    while (cyc < 8) @(negedge clk);
    vectors++; if (imem_req !== 1'b1 || pc !== 32'd4) begin
      miscompares++; $display("FAIL midfetch_setup: got req=%b pc=%h want 1/00000004", imem_req, pc);
    end
    reset_n = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0 || pc !== 32'd0 || retire_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++; $display("FAIL midfetch_async: got req=%b pc=%h rv=%b halted=%b want 0/0/0/0", imem_req, pc, retire_valid, halted);
    end
    dbg_reg_addr = 5'd5; #1;
    vectors++; if (dbg_reg_data !== X5_RESET) begin miscompares++; $display("FAIL midfetch_x5: got %h want %h", dbg_reg_data, X5_RESET); end
    @(negedge clk);
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL midfetch_req_low: got %b want 0", imem_req); end
    @(negedge clk);
    ret_cyc.delete();
    ret_rd.delete();
    ret_data.delete();
    addr_err = 0;
    reset_n = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL midfetch_refetch: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    run_to_halt(120);
    check_basic_retires("refetch", 7);
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic_program();
    test_shift_slt();
    test_alu_mix();
    test_wait_states();
    test_illegal();
    test_x0_write();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
